// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam int INSTR_W = 9;
  localparam logic [INSTR_W-1:0] HALT_OP = 9'b111000000;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating count of issued instructions; updates on the edge an issue occurs.
// Zero latency beyond the register; no backpressure, inc is sampled every edge.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// PC + instruction register in front of a combinational ROM; one word/cycle, 1-cycle fetch latency.
// stall freezes PC and IR; optional fetch_count port exists only with FETCH_PERF_CNT_EN defined.
module instr_fetch #(
  parameter int                   ROM_SIZE   = 256,
  parameter int                   INSTR_W    = fetch_pkg::INSTR_W,
  parameter int                   ADDR_W     = $clog2(ROM_SIZE),
  parameter logic [ADDR_W-1:0]    START_ADDR = '0,
  parameter logic [INSTR_W-1:0]   HALT_OP    = fetch_pkg::HALT_OP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        fetch_count
`endif
);

  import fetch_pkg::*;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc;
  logic              accept_start;
  logic              redirect;
  logic              issue;

  assign instr_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    redirect     = 1'b0;
    issue        = 1'b0;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          accept_start = 1'b1;
          state_d      = RUN;
        end
      end
      RUN: begin
        // A branch squashes the word fetched alongside it, HALT included.
        if (!stall) begin
          if (br_taken) begin
            redirect = 1'b1;
          end else begin
            issue = 1'b1;
            if (instr_in == HALT_OP) begin
              state_d = HALT;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      instr_out   <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (accept_start) begin
      pc          <= START_ADDR;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (redirect) begin
      pc          <= br_target;
      instr_valid <= 1'b0;
    end else if (issue) begin
      instr_out   <= instr_in;
      pc_out      <= pc;
      instr_valid <= 1'b1;
      pc          <= pc + ADDR_W'(1);
    end else if (state_q == HALT) begin
      instr_valid <= 1'b0;
      halted      <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (accept_start),
    .inc   (issue),
    .count (fetch_count)
  );
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Fetch unit bench: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a behavioural model of the fetch rules.
module tb_instr_fetch;

  localparam int ROM_SIZE = 256;
  localparam int HALT_W   = 448;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       br_taken = 1'b0;
  logic [7:0] br_target = '0;
  logic [7:0] instr_addr;
  logic [8:0] instr_in;
  logic [8:0] instr_out;
  logic       instr_valid;
  logic [7:0] pc_out;
  logic       halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
`endif

  logic [8:0] rom [ROM_SIZE];
  assign instr_in = rom[instr_addr];

  instr_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .instr_addr  (instr_addr),
    .instr_in    (instr_in),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .pc_out      (pc_out),
    .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 running, 2 stopped on HALT.
  bit m_known = 0;
  int m_mode, m_pc, m_pcout, m_out, m_cnt;
  bit m_valid, m_halted;

  always @(posedge clk) begin
    if (reset) begin
      m_known = 1; m_mode = 0; m_pc = 0; m_pcout = 0; m_out = 0;
      m_valid = 0; m_halted = 0; m_cnt = 0;
    end else if (m_known) begin
      if (m_mode == 1) begin
        if (stall) begin
        end else if (br_taken) begin
          m_pc = int'(br_target);
          m_valid = 0;
        end else begin
          m_out = int'(rom[m_pc]);
          m_pcout = m_pc;
          m_valid = 1;
          m_pc = (m_pc + 1) % ROM_SIZE;
          if (m_cnt < 65535) m_cnt++;
          if (m_out == HALT_W) m_mode = 2;
        end
      end else if (start) begin
        m_mode = 1; m_pc = 0; m_valid = 0; m_halted = 0; m_cnt = 0;
      end else if (m_mode == 2) begin
        m_valid = 0;
        m_halted = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("instr_addr", int'(instr_addr), m_pc);
      check("instr_valid", int'(instr_valid), int'(m_valid));
      check("halted", int'(halted), int'(m_halted));
      check("pc_out", int'(pc_out), m_pcout);
      check("instr_out", int'(instr_out), m_out);
`ifdef FETCH_PERF_CNT_EN
      check("fetch_count", int'(fetch_count), m_cnt);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_branch(input int tgt);
    br_taken = 1'b1;
    br_target = 8'(tgt);
    step();
    br_taken = 1'b0;
    check("br_bubble", int'(instr_valid), 0);
    step();
    check("br_pc", int'(pc_out), tgt);
    check("br_out", int'(instr_out), tgt);
    check("br_valid", int'(instr_valid), 1);
  endtask

  initial begin
    for (int i = 0; i < ROM_SIZE; i++) rom[i] = 9'(i);
    rom[84] = 9'b111000000;

    step(); step();
    reset = 1'b0;
    check("rst_valid", int'(instr_valid), 0);
    check("rst_halted", int'(halted), 0);
    check("rst_addr", int'(instr_addr), 0);
    check("rst_pcout", int'(pc_out), 0);
    check("rst_out", int'(instr_out), 0);

    start = 1'b1;
    step();
    start = 1'b0;
    check("start_addr", int'(instr_addr), 0);
    check("start_valid", int'(instr_valid), 0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("seq_pc", int'(pc_out), k);
      check("seq_out", int'(instr_out), k);
      check("seq_valid", int'(instr_valid), 1);
    end

    do_branch(2);
    step();
    check("pre_br_pc", int'(pc_out), 3);
    do_branch(40);

    do_branch(10);
    stall = 1'b1; br_taken = 1'b1; br_target = 8'd99;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_pc", int'(pc_out), 10);
      check("stall_out", int'(instr_out), 10);
      check("stall_valid", int'(instr_valid), 1);
      check("stall_addr", int'(instr_addr), 11);
    end
    stall = 1'b0; br_taken = 1'b0;
    step();
    check("resume_pc", int'(pc_out), 11);

    do_branch(82);
    step();
    step();
    check("halt_out", int'(instr_out), HALT_W);
    check("halt_valid", int'(instr_valid), 1);
    check("halt_early", int'(halted), 0);
    for (int k = 0; k < 2; k++) begin
      step();
      check("halted", int'(halted), 1);
      check("halted_valid", int'(instr_valid), 0);
      check("halted_addr", int'(instr_addr), 85);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_halted", int'(halted), 0);
    check("restart_addr", int'(instr_addr), 0);
    step();
    check("restart_pc", int'(pc_out), 0);
    check("restart_valid", int'(instr_valid), 1);

    do_branch(254);
    step();
    check("wrap_255", int'(pc_out), 255);
    step();
    check("wrap_0", int'(pc_out), 0);
    step();
    check("wrap_1", int'(pc_out), 1);

    reset = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    br_taken = 1'b1; br_target = 8'd20;
    step();
    br_taken = 1'b0;
    repeat (4) step();
    check("cnt_pc", int'(pc_out), 23);
`ifdef FETCH_PERF_CNT_EN
    check("cnt_seven", int'(fetch_count), 7);
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_valid", int'(instr_valid), 0);
    check("midrst_pc", int'(pc_out), 0);
`ifdef FETCH_PERF_CNT_EN
    check("midrst_cnt", int'(fetch_count), 0);
`endif

    for (int n = 0; n < 4000; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 19) == 0);
      stall     = ($urandom_range(0, 4) == 0);
      br_taken  = ($urandom_range(0, 9) == 0);
      br_target = 8'($urandom_range(0, 255));
      step();
    end
    reset = 1'b0; start = 1'b0; stall = 1'b0; br_taken = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
